// File: rtl/pgr_apb_slv_pkg.sv
// Shared definitions for the APB responder register bank: FSM state
// encoding and the value returned on reads outside the window.
package pgr_apb_slv_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [31:0] MISS_RDATA = 32'h0000_0000;

endpackage

// File: rtl/pgr_apb_slv_bytewr.sv
// One 32-bit read/write control word with per-byte-lane write enables.
module pgr_apb_slv_bytewr #(
  parameter logic [31:0] RST_VAL = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [3:0]  strb,
  input  logic [31:0] wdata,
  output logic [31:0] q
);

  // Update only the lanes whose strobe is set; an all-zero strobe leaves q as is.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: every word has an architectural reset value, so this storage is
    // flop-based and reset, unlike a RAM that would be left uninitialised.
    if (!rst_n) begin
      q <= RST_VAL;
    end else if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        // NOTE: sequential state is assigned with <= so every flop samples
        // pre-edge values regardless of statement order.
        if (strb[b]) q[8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/pgr_apb_slv_regbank_32bit.sv
// APB-style responder: decodes a word-aligned window holding RW control
// words and RO status words, answers each access with a single-cycle p_rdy
// after WAIT_CYC wait states, and aborts cleanly if p_ce drops while waiting.
module pgr_apb_slv_regbank_32bit
  import pgr_apb_slv_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter int          REG_NUM   = 16,
  parameter int          RW_NUM    = 8,
  parameter int          WAIT_CYC  = 2,
  parameter logic [31:0] RST_VAL   = 32'h0
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            p_sel,
  input  logic                            p_ce,
  input  logic                            p_we,
  input  logic [15:0]                     p_addr,
  input  logic [3:0]                      p_strb,
  input  logic [31:0]                     p_wdata,
  output logic                            p_rdy,
  output logic [31:0]                     p_rdata,
  output logic [RW_NUM*32-1:0]            ctrl_regs,
  input  logic [(REG_NUM-RW_NUM)*32-1:0]  sts_in,
  output logic [RW_NUM-1:0]               wr_stb,
  output logic [REG_NUM-1:0]              rd_stb
);

  localparam int         IDX_W    = $clog2(REG_NUM);
  localparam logic [7:0] CNT_LOAD = (WAIT_CYC > 0) ? 8'(WAIT_CYC - 1) : 8'd0;

  logic [1:0]       state;
  logic [7:0]       cnt;
  logic             ce_hold;   // transfer just finished, p_ce not yet dropped
  logic             start;
  logic             go_resp;   // this edge enters RESP: commit write, latch read
  logic             hit;
  logic [IDX_W-1:0] idx;
  logic [31:0]      rd_word;
  logic [RW_NUM-1:0] wr_en;
  logic [31:0]      word_q    [RW_NUM];
  logic [31:0]      all_words [REG_NUM];

  assign hit   = (p_addr[15:2+IDX_W] == BASE_ADDR[15:2+IDX_W]);
  assign idx   = p_addr[1+IDX_W:2];
  assign p_rdy = (state == ST_RESP);

  // Start and commit conditions for the current cycle.
  always_comb begin
    // NOTE: defaults first so no path through the block leaves a signal
    // unassigned, which would infer a latch.
    start   = 1'b0;
    go_resp = 1'b0;
    if (state == ST_IDLE) begin
      start   = p_sel && p_ce && !ce_hold;
      go_resp = start && (WAIT_CYC == 0);
    end else if (state == ST_WAIT) begin
      go_resp = p_ce && (cnt == 8'd0);
    end
  end

  // Word storage and the flat/array views used by the read mux and outputs.
  for (genvar g = 0; g < REG_NUM; g++) begin : g_word
    if (g < RW_NUM) begin : g_rw
      assign wr_en[g] = go_resp && p_we && hit && (idx == IDX_W'(g));
      pgr_apb_slv_bytewr #(.RST_VAL(RST_VAL)) u_word (
        .clk   (clk),
        .rst_n (rst_n),
        .wr_en (wr_en[g]),
        .strb  (p_strb),
        .wdata (p_wdata),
        .q     (word_q[g])
      );
      assign ctrl_regs[32*g +: 32] = word_q[g];
      assign all_words[g]          = word_q[g];
    end else begin : g_ro
      assign all_words[g] = sts_in[32*(g-RW_NUM) +: 32];
    end
  end

  assign rd_word = all_words[idx];

  // Access FSM with wait-state counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= 8'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (WAIT_CYC == 0) begin
              state <= ST_RESP;
            end else begin
              state <= ST_WAIT;
              cnt   <= CNT_LOAD;
            end
          end
        end
        ST_WAIT: begin
          if (!p_ce)              state <= ST_IDLE;
          else if (cnt == 8'd0)   state <= ST_RESP;
          else                    cnt   <= cnt - 8'd1;
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Block a restart until the master has released p_ce after a completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 ce_hold <= 1'b0;
    else if (state == ST_RESP)  ce_hold <= 1'b1;
    else if (!p_ce)             ce_hold <= 1'b0;
  end

  // Response data and one-cycle access strobes, registered entering RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_rdata <= 32'h0;
      wr_stb  <= '0;
      rd_stb  <= '0;
    end else begin
      wr_stb <= wr_en;
      rd_stb <= '0;
      if (go_resp) begin
        if (p_we) begin
          p_rdata <= 32'h0;
        end else if (hit) begin
          p_rdata <= rd_word;
          rd_stb  <= REG_NUM'(1) << idx;
        end else begin
          p_rdata <= MISS_RDATA;
        end
      end
    end
  end

endmodule

// File: tb/tb_pgr_apb_slv_regbank_32bit.sv
// Directed bench for pgr_apb_slv_regbank_32bit with default parameters
// (16 words, 8 RW, 2 wait states, window at 0x0000).
module tb_pgr_apb_slv_regbank_32bit;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         p_sel = 1'b0;
  logic         p_ce = 1'b0;
  logic         p_we = 1'b0;
  logic [15:0]  p_addr = '0;
  logic [3:0]   p_strb = '0;
  logic [31:0]  p_wdata = '0;
  logic         p_rdy;
  logic [31:0]  p_rdata;
  logic [255:0] ctrl_regs;
  logic [255:0] sts_in = '0;
  logic [7:0]   wr_stb;
  logic [15:0]  rd_stb;

  int n_checks = 0;
  int n_fail   = 0;

  // Results captured by xfer
  int           r_rdy_cnt, r_lat, r_wr_pulses, r_rd_pulses;
  logic [31:0]  r_rdata;
  logic [7:0]   r_wr_stb;
  logic [15:0]  r_rd_stb;
  logic [255:0] r_ctrl;

  logic [255:0] exp_ctrl = '0;

  pgr_apb_slv_regbank_32bit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .p_sel     (p_sel),
    .p_ce      (p_ce),
    .p_we      (p_we),
    .p_addr    (p_addr),
    .p_strb    (p_strb),
    .p_wdata   (p_wdata),
    .p_rdy     (p_rdy),
    .p_rdata   (p_rdata),
    .ctrl_regs (ctrl_regs),
    .sts_in    (sts_in),
    .wr_stb    (wr_stb),
    .rd_stb    (rd_stb)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One transfer; abort_at>0 drops p_ce at that sampled cycle (no completion expected).
  task automatic xfer(input logic we, input logic [15:0] addr, input logic [3:0] strb,
                      input logic [31:0] wdata, input int abort_at);
    r_rdy_cnt = 0; r_lat = 0; r_wr_pulses = 0; r_rd_pulses = 0;
    r_rdata = 'x; r_wr_stb = '0; r_rd_stb = '0; r_ctrl = ctrl_regs;
    @(negedge clk);
    p_sel = 1'b1; p_we = we; p_addr = addr; p_strb = strb; p_wdata = wdata;
    @(negedge clk);
    p_ce = 1'b1;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(negedge clk);
      if (p_rdy) begin
        r_rdy_cnt++;
        if (r_lat == 0) begin
          r_lat    = cyc;
          r_rdata  = p_rdata;
          r_wr_stb = wr_stb;
          r_rd_stb = rd_stb;
          r_ctrl   = ctrl_regs;
        end
      end
      if (wr_stb != '0) r_wr_pulses++;
      if (rd_stb != '0) r_rd_pulses++;
      if (abort_at > 0 && cyc == abort_at) begin
        p_ce = 1'b0; p_sel = 1'b0;
      end
      // Hold p_ce through the cycle after p_rdy (and a bit more) to confirm no restart
      if (r_lat > 0 && cyc == r_lat + 3) begin
        p_ce = 1'b0; p_sel = 1'b0;
        break;
      end
    end
    if (abort_at == 0 && r_lat == 0) begin
      p_ce = 1'b0; p_sel = 1'b0;
    end
    @(negedge clk);
    if (abort_at > 0) r_ctrl = ctrl_regs;
  endtask

  initial begin
    sts_in[32*1 +: 32] = 32'hCAFE_0009;   // word 9
    sts_in[32*7 +: 32] = 32'h5555_000F;   // word 15

    repeat (2) @(negedge clk);
    check("rst_p_rdy",   {255'b0, p_rdy}, '0);
    check("rst_p_rdata", p_rdata, '0);
    check("rst_wr_stb",  wr_stb, '0);
    check("rst_rd_stb",  rd_stb, '0);
    check("rst_ctrl",    ctrl_regs, '0);
    rst_n = 1'b1;
    @(negedge clk);

    // Full write to word 3
    xfer(1'b1, 16'h000C, 4'hF, 32'h1234_5678, 0);
    exp_ctrl[32*3 +: 32] = 32'h1234_5678;
    check("w3_rdy_cnt", r_rdy_cnt, 1);
    check("w3_latency", r_lat, 3);
    check("w3_ctrl",    r_ctrl[32*3 +: 32], 32'h1234_5678);
    check("w3_wr_stb",  r_wr_stb, 8'h08);
    check("w3_wr_puls", r_wr_pulses, 1);
    check("w3_rd_puls", r_rd_pulses, 0);
    check("w3_rdata",   r_rdata, 32'h0);

    // Partial write, lanes 0 and 2
    xfer(1'b1, 16'h000C, 4'b0101, 32'hAABB_CCDD, 0);
    exp_ctrl[32*3 +: 32] = 32'h12BB_56DD;
    check("pw_ctrl", r_ctrl, exp_ctrl);
    xfer(1'b0, 16'h000C, 4'h0, 32'h0, 0);
    check("pw_rdata",  r_rdata, 32'h12BB_56DD);
    check("pw_rd_stb", r_rd_stb, 16'h0008);

    // Status word 9: read, then a dropped write
    xfer(1'b0, 16'h0024, 4'h0, 32'h0, 0);
    check("s9_rdata",   r_rdata, 32'hCAFE_0009);
    check("s9_rd_stb",  r_rd_stb, 16'h0200);
    check("s9_rd_puls", r_rd_pulses, 1);
    xfer(1'b1, 16'h0024, 4'hF, 32'hFFFF_FFFF, 0);
    check("s9w_rdy",     r_rdy_cnt, 1);
    check("s9w_wr_puls", r_wr_pulses, 0);
    check("s9w_rdata",   r_rdata, 32'h0);
    check("s9w_ctrl",    r_ctrl, exp_ctrl);

    // Last status word and miss read
    xfer(1'b0, 16'h003C, 4'h0, 32'h0, 0);
    check("s15_rdata", r_rdata, 32'h5555_000F);
    xfer(1'b0, 16'h0100, 4'h0, 32'h0, 0);
    check("miss_rdy",     r_rdy_cnt, 1);
    check("miss_rdata",   r_rdata, 32'h0);
    check("miss_rd_puls", r_rd_pulses, 0);
    check("miss_wr_puls", r_wr_pulses, 0);
    xfer(1'b1, 16'h010C, 4'hF, 32'hFFFF_FFFF, 0);
    check("missw_ctrl",   r_ctrl, exp_ctrl);

    // Last RW word
    xfer(1'b1, 16'h001C, 4'hF, 32'h7777_0007, 0);
    exp_ctrl[32*7 +: 32] = 32'h7777_0007;
    check("w7_wr_stb", r_wr_stb, 8'h80);
    check("w7_ctrl",   r_ctrl, exp_ctrl);

    // Abort in second wait cycle
    xfer(1'b1, 16'h000C, 4'hF, 32'hFFFF_FFFF, 2);
    check("ab_rdy",     r_rdy_cnt, 0);
    check("ab_wr_puls", r_wr_pulses, 0);
    check("ab_ctrl",    r_ctrl, exp_ctrl);
    xfer(1'b0, 16'h000C, 4'h0, 32'h0, 0);
    check("ab_next_lat",   r_lat, 3);
    check("ab_next_rdata", r_rdata, 32'h12BB_56DD);

    // p_sel without p_ce does nothing
    @(negedge clk);
    p_sel = 1'b1; p_we = 1'b1; p_addr = 16'h0000; p_strb = 4'hF; p_wdata = 32'h1;
    begin
      int seen = 0;
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        if (p_rdy) seen++;
      end
      check("sel_only_rdy",  seen, 0);
      check("sel_only_ctrl", ctrl_regs, exp_ctrl);
    end
    p_sel = 1'b0;
    @(negedge clk);

    // Reset during WAIT
    p_sel = 1'b1; p_we = 1'b1; p_addr = 16'h0014; p_strb = 4'hF; p_wdata = 32'h0BAD_F00D;
    @(negedge clk);
    p_ce = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rstw_rdy",  {255'b0, p_rdy}, '0);
    check("rstw_ctrl", ctrl_regs, '0);
    @(negedge clk);
    check("rstw_rdy2", {255'b0, p_rdy}, '0);
    p_ce = 1'b0; p_sel = 1'b0;
    rst_n = 1'b1;
    exp_ctrl = '0;
    @(negedge clk);

    // Back-to-back write then read of word 0
    xfer(1'b1, 16'h0000, 4'hF, 32'hA5A5_5A5A, 0);
    check("b2b_w_stb", r_wr_stb, 8'h01);
    xfer(1'b0, 16'h0000, 4'h0, 32'h0, 0);
    check("b2b_rdata", r_rdata, 32'hA5A5_5A5A);
    check("b2b_rd_stb", r_rd_stb, 16'h0001);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pgr_apb_slv_regbank_32bit.md
# pgr_apb_slv_regbank_32bit

APB-style responder terminating the 32-bit p_sel/p_ce/p_we/p_rdy bus driven by the UART-to-APB master. It decodes a word-aligned window, holds a bank of read/write control registers and read-only status words, and answers each access with a single-cycle p_rdy after a programmable number of wait states. It sits on the fabric side of the uart2apb bridge, in front of the design's configuration and status logic.

## Interface
- BASE_ADDR, 16'h0000, byte base address of the window; aligned to REG_NUM*4
- REG_NUM, 16, total 32-bit words in the window; power of two, 2..64
- RW_NUM, 8, words 0..RW_NUM-1 are read/write; RW_NUM..REG_NUM-1 are read-only status; 1..REG_NUM
- WAIT_CYC, 2, wait states between access start and p_rdy; 0..200, so the master's 255-cycle timeout never fires
- RST_VAL, 32'h0, reset value of every RW register
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- p_sel  in  1  transfer select (setup phase)
- p_ce  in  1  access enable; high from one cycle after p_sel until the cycle after p_rdy
- p_we  in  1  1 = write, 0 = read
- p_addr  in  16  byte address, stable while p_sel high
- p_strb  in  4  write byte-lane enables, bit n covers p_wdata[8n+7:8n]
- p_wdata  in  32  write data
- p_rdy  out  1  single-cycle completion strobe
- p_rdata  out  32  read data, valid in the p_rdy cycle
- ctrl_regs  out  RW_NUM*32  flattened RW register contents, word i at [32i+31:32i]
- sts_in  in  (REG_NUM-RW_NUM)*32  flattened status words, sampled at response
- wr_stb  out  RW_NUM  one-hot pulse, word written this cycle
- rd_stb  out  REG_NUM  one-hot pulse, word read this cycle

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: p_sel & p_ce sampled high -> WAIT if WAIT_CYC>0 (counter loaded WAIT_CYC-1), else RESP.
- WAIT: counter decrements; when it is 0 and p_ce is high -> RESP. p_ce low in WAIT (master timeout/abort) -> IDLE, no write, no p_rdy, no strobes.
- RESP: p_rdy=1 for exactly one cycle, then IDLE unconditionally. IDLE does not restart while p_ce stays high from the same transfer; a new transfer needs p_ce low for at least one cycle.
- Decode: hit = p_addr[15:2+log2(REG_NUM)] == BASE_ADDR[15:2+log2(REG_NUM)]; index = p_addr[1+log2(REG_NUM):2]. p_addr[1:0] ignored.
- Write hit to RW word: lanes with p_strb=1 updated on the edge entering RESP; wr_stb[index] pulses in the p_rdy cycle, including when p_strb=4'h0, which leaves the data unchanged. Writes to RO words or misses are dropped and raise no wr_stb. Writes still complete with p_rdy.
- Read: p_rdata is registered on the edge entering RESP. A hit on an RW word returns the register. A hit on an RO word returns the sts_in word sampled on that edge. A miss returns 32'h0000_0000. rd_stb[index] pulses on a hit only.
- On a write, p_rdata returns 32'h0. p_rdata holds its value outside RESP.

## Timing
- Reset values: p_rdy=0, p_rdata=0, wr_stb=0, rd_stb=0, every RW register = RST_VAL, FSM = IDLE, counter = 0.
- Latency: p_ce first sampled high on edge e -> p_rdy high in cycle e+1+WAIT_CYC. A complete transfer, cmd_en to p_ce low, takes WAIT_CYC+4 cycles.
- Write data is visible on ctrl_regs in the p_rdy cycle.
- Reset asserted mid-transfer: immediate return to IDLE, no p_rdy, registers return to RST_VAL.
- p_sel high with p_ce low: no action.

## Structure
- The package pgr_apb_slv_pkg holds the FSM state encoding (2 bits: IDLE=0, WAIT=1, RESP=2) and MISS_RDATA=32'h0.
- One sub-module, pgr_apb_slv_bytewr, implements a single RW word with per-lane strobe write and RST_VAL reset. It is instantiated RW_NUM times in a generate loop.
- The FSM, counter, decode and read mux live in the top module.

## Test plan
- Write to word 3, addr 16'h000C, data 32'h1234_5678, strb 4'hF, WAIT_CYC=2 -> p_rdy exactly 3 cycles after p_ce rises; ctrl_regs word 3 = 32'h1234_5678; wr_stb[3] is a single pulse.
- Partial write, strb 4'b0101, data 32'hAABB_CCDD, onto 32'h1234_5678 -> word reads back 32'h12BB_56DD.
- Read status word 9 with sts_in word = 32'hCAFE_0009 -> p_rdata = 32'hCAFE_0009 in the p_rdy cycle; rd_stb[9] pulses. A write to word 9 raises no wr_stb and leaves nothing changed.
- Miss read at 16'h0100 (window 0x00-0x3F) -> p_rdy still asserted, p_rdata = 0, no strobes.
- Abort: drop p_ce in the second WAIT cycle during a write -> no p_rdy, register unchanged. The next read completes normally.
- Reset asserted in WAIT -> p_rdy stays 0 and all RW registers equal RST_VAL. A back-to-back write then read of word 0 returns the written value.
